// File: rtl/rr_lock_arbiter_pkg.sv
// Shared state encoding and elaboration helpers for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between N requesters and the lock arbiter.
interface rr_lock_arbiter_if #(
    parameter int N    = 4,
    parameter int LOGN = 2
);
    // Protocol: a requester holds req[i] until it sees gnt[i]; while gnt_valid=1
    // the owner keeps the resource until it pulses done, drops req[i], or the
    // arbiter revokes it (preempt=1 in that last owned cycle).
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [LOGN-1:0] gnt_idx;
    logic            gnt_valid;
    logic            preempt;
    logic            state;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, preempt, state
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, preempt, state
    );
endinterface

// File: rtl/rr_lock_arbiter_pick.sv
// Combinational rotating-priority picker: rotate, fixed-priority chain, rotate back, encode.
module rr_pick #(
    parameter int N    = 4,
    parameter int LOGN = 2
) (
    input  logic [N-1:0]    req,
    input  logic [LOGN-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    win,
    output logic [LOGN-1:0] idx,
    output logic            any
);
    localparam logic [LOGN:0] N_W = (LOGN + 1)'(N);

    function automatic logic [LOGN-1:0] wrap(input logic [LOGN:0] sum);
        return (sum >= N_W) ? LOGN'(sum - N_W) : sum[LOGN-1:0];
    endfunction

    logic [N-1:0] avail;
    logic [N-1:0] rot;
    logic [N-1:0] rot_win;
    logic         seen;

    always_comb begin
        avail   = req & ~mask;
        rot     = '0;
        rot_win = '0;
        win     = '0;
        idx     = '0;
        seen    = 1'b0;
        // rot[0] is the requester at ptr, i.e. the current highest priority
        for (int i = 0; i < N; i++) begin
            rot[i] = avail[wrap((LOGN + 1)'(i) + {1'b0, ptr})];
        end
        for (int i = 0; i < N; i++) begin
            rot_win[i] = rot[i] & ~seen;
            seen       = seen | rot[i];
        end
        for (int i = 0; i < N; i++) begin
            win[wrap((LOGN + 1)'(i) + {1'b0, ptr})] = rot_win[i];
        end
        for (int i = 0; i < N; i++) begin
            if (win[i]) idx = idx | LOGN'(i);
        end
        any = |avail;
    end
endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the grant to its owner until done, request drop or hold-budget expiry.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int LOGN    = 2,
    parameter int MAXHOLD = 16
) (
    input logic           clk,
    input logic           reset,
    rr_lock_arbiter_if.slave bus
);
    localparam int            CW  = (MAXHOLD > 1) ? clog2(MAXHOLD) : 1;
    localparam logic [LOGN:0] N_W = (LOGN + 1)'(N);

    if (LOGN != clog2(N) || N < 2 || N > 16) begin : g_bad_params
        $error("rr_lock_arbiter: N must be 2..16 and LOGN must equal clog2(N)");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [LOGN-1:0] idx_q, idx_d;
    logic [LOGN-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    win;
    logic [LOGN-1:0] win_idx;
    logic            win_any;
    logic            owned, owner_req, others, budget_hit, release_c;

    function automatic logic [LOGN-1:0] next_ptr(input logic [LOGN-1:0] owner);
        logic [LOGN:0] t;
        t = {1'b0, owner} + 1'b1;
        return (t == N_W) ? '0 : t[LOGN-1:0];
    endfunction

    // Masking with gnt_q removes the current owner; in IDLE gnt_q is zero.
    rr_pick #(.N(N), .LOGN(LOGN)) u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .mask (gnt_q),
        .win  (win),
        .idx  (win_idx),
        .any  (win_any)
    );

    always_comb begin
        owned      = (state_q == S_OWNED);
        owner_req  = |(bus.req & gnt_q);
        others     = |(bus.req & ~gnt_q);
        budget_hit = (MAXHOLD != 0) && (int'(cnt_q) == MAXHOLD - 1) && others;
        release_c  = bus.done || !owner_req || budget_hit;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    state_d = S_OWNED;
                    gnt_d   = win;
                    idx_d   = win_idx;
                    ptr_d   = next_ptr(win_idx);
                    cnt_d   = '0;
                end
            end
            S_OWNED: begin
                if (!release_c) begin
                    if (int'(cnt_q) < MAXHOLD - 1) cnt_d = cnt_q + CW'(1);
                end else if (win_any) begin
                    gnt_d = win;
                    idx_d = win_idx;
                    ptr_d = next_ptr(win_idx);
                    cnt_d = '0;
                end else if (owner_req && !bus.done) begin
                    // Sole requester re-granted; pointer already sits past it.
                    cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.preempt   = owned && budget_hit && !bus.done && owner_req;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: N=4/MAXHOLD=16 and N=3/MAXHOLD=1 instances against a queue-fed reference model.
module tb_rr_lock_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_lock_arbiter_if #(.N(4), .LOGN(2)) ifa ();
    rr_lock_arbiter_if #(.N(3), .LOGN(2)) ifb ();

    rr_lock_arbiter #(.N(4), .LOGN(2), .MAXHOLD(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    rr_lock_arbiter #(.N(3), .LOGN(2), .MAXHOLD(1))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner (-1 idle), rotating pointer, cycles held so far, last index
    int m_own[2];
    int m_ptr[2];
    int m_held[2];
    int m_last[2];

    logic [8:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    logic [8:0] got_a, exp_a;
    logic [7:0] got_b, exp_b;

    assign got_a = {ifa.gnt, ifa.gnt_idx, ifa.gnt_valid, ifa.state, ifa.preempt};
    assign got_b = {ifb.gnt, ifb.gnt_idx, ifb.gnt_valid, ifb.state, ifb.preempt};

    function automatic int pick(input logic [15:0] r, input int p, input int excl, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (((r >> c) & 16'd1) != 16'd0 && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_own[u]  = -1;
            m_ptr[u]  = 0;
            m_held[u] = 0;
            m_last[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input int n, input int mh, input logic [15:0] req,
                              input logic dn, output logic [15:0] eg, output logic [3:0] ei,
                              output logic ev, output logic ep);
        int w, o;
        bit others, budget, rel, oreq;
        ev = (m_own[u] >= 0);
        eg = ev ? (16'd1 << m_own[u]) : 16'd0;
        ei = 4'(m_last[u]);
        ep = 1'b0;
        w  = -1;
        if (m_own[u] < 0) begin
            w = pick(req, m_ptr[u], -1, n);
        end else begin
            o      = m_own[u];
            oreq   = ((req >> o) & 16'd1) != 16'd0;
            others = (req & ~(16'd1 << o)) != 16'd0;
            budget = (mh != 0) && (m_held[u] >= mh) && others;
            rel    = dn || !oreq || budget;
            ep     = budget && !dn && oreq;
            if (!rel) begin
                m_held[u]++;
            end else begin
                w = pick(req, m_ptr[u], o, n);
                if (w < 0) begin
                    if (oreq && !dn) m_held[u] = 1;
                    else m_own[u] = -1;
                end
            end
        end
        if (w >= 0) begin
            m_own[u]  = w;
            m_last[u] = w;
            m_ptr[u]  = (w + 1) % n;
            m_held[u] = 1;
        end
    endtask

    // One clock cycle: apply inputs after the edge, predict at mid-cycle.
    task automatic drive(input logic [3:0] ra, input logic da, input logic [2:0] rb, input logic db);
        logic [15:0] eg;
        logic [3:0]  ei;
        logic        ev, ep;
        @(posedge clk);
        #1;
        ifa.req  = ra;
        ifa.done = da;
        ifb.req  = rb;
        ifb.done = db;
        @(negedge clk);
        model_step(0, 4, 16, {12'b0, ra}, da, eg, ei, ev, ep);
        exp_q_a.push_back({eg[3:0], ei[1:0], ev, ev, ep});
        model_step(1, 3, 1, {13'b0, rb}, db, eg, ei, ev, ep);
        exp_q_b.push_back({eg[2:0], ei[1:0], ev, ev, ep});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        ifa.req  = '0;
        ifa.done = 1'b0;
        ifb.req  = '0;
        ifb.done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ifa.req  = '0;
        ifa.done = 1'b0;
        ifb.req  = '0;
        ifb.done = 1'b0;
        #1;
        compared++;
        if (got_a !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_a got=%b exp=%b", got_a, 9'd0);
        end
        compared++;
        if (got_b !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_b got=%b exp=%b", got_b, 8'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_alternate();
        logic [3:0] seq_g[5];
        logic [1:0] seq_i[5];
        seq_g = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
        seq_i = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0101, 1'b1, 3'b000, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL alternate_model cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
            compared++;
            if (ifa.gnt !== seq_g[c] || ifa.gnt_idx !== seq_i[c]) begin
                mismatched++;
                $display("FAIL alternate_seq cyc=%0d got=%b/%0d exp=%b/%0d",
                         c, ifa.gnt, ifa.gnt_idx, seq_g[c], seq_i[c]);
            end
        end
        exp_q_b.delete();
    endtask

    task automatic test_budget();
        int n_own, n_pre, pre_cyc;
        n_own = 0; n_pre = 0; pre_cyc = -1;
        do_reset();
        for (int c = 0; c < 19; c++) begin
            drive((c == 0) ? 4'b0010 : 4'b1111, 1'b0, 3'b000, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL budget_model cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
            if (ifa.gnt == 4'b0010) n_own++;
            if (ifa.preempt) begin
                n_pre++;
                pre_cyc = c;
            end
            if (c == 17) begin
                compared++;
                if (ifa.gnt !== 4'b0100) begin
                    mismatched++;
                    $display("FAIL budget_next got=%b exp=%b", ifa.gnt, 4'b0100);
                end
            end
        end
        compared++;
        if (n_own != 16 || n_pre != 1 || pre_cyc != 16) begin
            mismatched++;
            $display("FAIL budget_hold got own=%0d pre=%0d at %0d exp own=16 pre=1 at 16",
                     n_own, n_pre, pre_cyc);
        end
        exp_q_b.delete();
    endtask

    task automatic test_sole();
        int n_pre, n_bad;
        n_pre = 0; n_bad = 0;
        do_reset();
        for (int c = 0; c < 41; c++) begin
            drive(4'b1000, 1'b0, 3'b000, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL sole_model cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
            if (ifa.preempt) n_pre++;
            if (c >= 1 && ifa.gnt !== 4'b1000) n_bad++;
        end
        compared++;
        if (n_pre != 0 || n_bad != 0) begin
            mismatched++;
            $display("FAIL sole_hold got pre=%0d bad_gnt=%0d exp 0/0", n_pre, n_bad);
        end
        exp_q_b.delete();
    endtask

    task automatic test_done_at_budget();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive((c == 0) ? 4'b0100 : 4'b0111, (c == 16), 3'b000, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL done_budget_model cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
            if (c == 16) begin
                compared++;
                if (ifa.preempt !== 1'b0 || ifa.gnt !== 4'b0100) begin
                    mismatched++;
                    $display("FAIL done_budget_pre got pre=%b gnt=%b exp pre=0 gnt=0100",
                             ifa.preempt, ifa.gnt);
                end
            end
            if (c == 17) begin
                compared++;
                if (ifa.gnt !== 4'b0001) begin
                    mismatched++;
                    $display("FAIL done_budget_next got=%b exp=%b", ifa.gnt, 4'b0001);
                end
            end
        end
        exp_q_b.delete();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 1'b0, 3'b011, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL areset_pre cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
        end
        #2;
        reset    = 1'b1;
        ifa.req  = '0;
        ifb.req  = '0;
        #1;
        compared++;
        if (ifa.gnt !== 4'b0000 || ifa.gnt_valid !== 1'b0 || ifb.gnt !== 3'b000) begin
            mismatched++;
            $display("FAIL areset_clear got gnt_a=%b valid_a=%b gnt_b=%b exp 0000/0/000",
                     ifa.gnt, ifa.gnt_valid, ifb.gnt);
        end
        #1;
        reset = 1'b0;
        model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0010, 1'b0, 3'b000, 1'b0);
            exp_a = exp_q_a.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL areset_post_model cyc=%0d got=%b exp=%b", c, got_a, exp_a);
            end
            compared++;
            if (ifa.gnt !== ((c == 0) ? 4'b0000 : 4'b0010)) begin
                mismatched++;
                $display("FAIL areset_regrant cyc=%0d got=%b exp=%b", c, ifa.gnt,
                         (c == 0) ? 4'b0000 : 4'b0010);
            end
        end
        exp_q_b.delete();
    endtask

    task automatic test_rotate();
        logic [2:0] exp_rot;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(4'b0000, 1'b0, 3'b111, 1'b0);
            exp_b = exp_q_b.pop_front();
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL rotate_model cyc=%0d got=%b exp=%b", c, got_b, exp_b);
            end
            if (c >= 1) begin
                exp_rot = 3'(1 << ((c - 1) % 3));
                compared++;
                if (ifb.gnt !== exp_rot || ifb.preempt !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rotate_seq cyc=%0d got gnt=%b pre=%b exp gnt=%b pre=1",
                             c, ifb.gnt, ifb.preempt, exp_rot);
                end
            end
        end
        exp_q_a.delete();
    endtask

    task automatic test_random();
        logic [3:0] ra;
        logic [2:0] rb;
        ra = '0;
        rb = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = 3'($urandom_range(0, 7));
            drive(ra, ($urandom_range(0, 7) == 0), rb, ($urandom_range(0, 5) == 0));
            exp_a = exp_q_a.pop_front();
            exp_b = exp_q_b.pop_front();
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL random_a cyc=%0d req=%b got=%b exp=%b", c, ra, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL random_b cyc=%0d req=%b got=%b exp=%b", c, rb, got_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_budget();
        test_sole();
        test_done_at_budget();
        test_async_reset();
        test_rotate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
